// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: streams LANES lane pairs through one shared scalar ALU,
// one lane per cycle, and assembles the per-lane results into a vector.
module vector_alu_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Start,
    input  logic [2:0]              ALUControlIn,
    input  logic [LANES*LANE_W-1:0] SrcA,
    input  logic [LANES*LANE_W-1:0] SrcB,
    input  logic                    Abort,
    output logic                    Ready,
    output logic [2:0]              ALUControl,
    output logic [LANE_W-1:0]       ALUSrcA,
    output logic [LANE_W-1:0]       ALUSrcB,
    input  logic [LANE_W-1:0]       ALUResult,
    output logic [LANES*LANE_W-1:0] Result,
    output logic [LANES-1:0]        LaneZero,
    output logic                    Done,
    output logic                    Error
);

    localparam int VW = LANES * LANE_W;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    lane_q, lane_d;
    logic [2:0]       op_q, op_d;
    logic [VW-1:0]    opa_q, opa_d;
    logic [VW-1:0]    opb_q, opb_d;
    logic [VW-1:0]    res_q, res_d;
    logic [LANES-1:0] zero_q, zero_d;
    logic             err_q, err_d;
    logic             accept;
    logic             unsup_in;

    assign unsup_in = (ALUControlIn > 3'd2);
    // Abort outranks Start while idle
    assign accept   = (state_q == S_IDLE) && Start && !Abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = unsup_in ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (lane_q == LAST) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Ready      = 1'b0;
        Done       = 1'b0;
        Error      = 1'b0;
        ALUControl = 3'b000;
        ALUSrcA    = '0;
        ALUSrcB    = '0;
        unique case (state_q)
            S_IDLE: Ready = 1'b1;
            S_ISSUE: begin
                ALUControl = op_q;
                ALUSrcA    = opa_q[lane_q*LANE_W +: LANE_W];
                ALUSrcB    = opb_q[lane_q*LANE_W +: LANE_W];
            end
            S_FINISH: begin
                Done  = !Abort;
                Error = !Abort && err_q;
            end
            default: ;
        endcase
    end

    // An aborted ISSUE cycle writes nothing; earlier lanes keep their values
    always_comb begin
        lane_d = lane_q;
        op_d   = op_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        err_d  = err_q;
        res_d  = res_q;
        zero_d = zero_q;
        if (accept) begin
            lane_d = '0;
            op_d   = ALUControlIn;
            opa_d  = SrcA;
            opb_d  = SrcB;
            err_d  = unsup_in;
        end else if (state_q == S_ISSUE && !Abort) begin
            res_d[lane_q*LANE_W +: LANE_W] = ALUResult;
            zero_d[lane_q] = (ALUResult == '0);
            if (lane_q != LAST) begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            op_q   <= 3'b000;
            opa_q  <= '0;
            opb_q  <= '0;
            err_q  <= 1'b0;
            res_q  <= '0;
            zero_q <= '0;
        end else begin
            lane_q <= lane_d;
            op_q   <= op_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            err_q  <= err_d;
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

    assign Result   = res_q;
    assign LaneZero = zero_q;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Bench for vector_alu_sequencer: timeline reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_vector_alu_sequencer;

    localparam int LANES = 4;
    localparam int W     = 32;
    localparam int VW    = LANES * W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            Start;
    logic [2:0]      ALUControlIn;
    logic [VW-1:0]   SrcA;
    logic [VW-1:0]   SrcB;
    logic            Abort;
    logic            Ready;
    logic [2:0]      ALUControl;
    logic [W-1:0]    ALUSrcA;
    logic [W-1:0]    ALUSrcB;
    logic [W-1:0]    ALUResult;
    logic [VW-1:0]   Result;
    logic [LANES-1:0] LaneZero;
    logic            Done;
    logic            Error;

    int checks = 0;
    int errors = 0;

    vector_alu_sequencer #(.LANES(LANES), .LANE_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start),
        .ALUControlIn(ALUControlIn), .SrcA(SrcA), .SrcB(SrcB),
        .Abort(Abort), .Ready(Ready), .ALUControl(ALUControl),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUResult(ALUResult),
        .Result(Result), .LaneZero(LaneZero), .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Shared scalar ALU
    always_comb begin
        ALUResult = '0;
        ALUResult = alu_f(ALUControl, ALUSrcA, ALUSrcB);
    end

    task automatic check(input string nm, input logic [VW-1:0] act,
                         input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: time since accept drives everything
    bit           mact = 1'b0;
    bit           munsup = 1'b0;
    int           mt = 0;
    bit [2:0]     mop = '0;
    bit [W-1:0]   mA[LANES];
    bit [W-1:0]   mB[LANES];
    bit [W-1:0]   mRes[LANES];
    bit           mZ[LANES];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mact = 1'b0;
            mt = 0;
            for (int i = 0; i < LANES; i++) begin
                mRes[i] = '0;
                mZ[i] = 1'b0;
            end
        end else if (!mact) begin
            if (Start && !Abort) begin
                mact = 1'b1;
                mt = 0;
                mop = ALUControlIn;
                munsup = (ALUControlIn > 3'd2);
                for (int i = 0; i < LANES; i++) begin
                    mA[i] = SrcA[i*W +: W];
                    mB[i] = SrcB[i*W +: W];
                end
            end
        end else if (Abort) begin
            mact = 1'b0;
        end else begin
            mt++;
            if (!munsup && mt <= LANES) begin
                mRes[mt-1] = alu_f(mop, mA[mt-1], mB[mt-1]);
                mZ[mt-1] = (mRes[mt-1] == 0);
            end
            if ((munsup && mt == 1) || mt == LANES + 1) mact = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        bit [VW-1:0]    er;
        bit [LANES-1:0] ez;
        bit             iss;
        bit             dn;
        for (int i = 0; i < LANES; i++) begin
            er[i*W +: W] = mRes[i];
            ez[i] = mZ[i];
        end
        iss = mact && !munsup && mt < LANES;
        dn = mact && !Abort && (munsup ? (mt == 0) : (mt == LANES));
        check("Ready", Ready, !mact);
        check("Done", Done, dn);
        check("Error", Error, dn && munsup);
        check("ALUControl", ALUControl, iss ? mop : 3'd0);
        check("ALUSrcA", ALUSrcA, iss ? mA[mt] : '0);
        check("ALUSrcB", ALUSrcB, iss ? mB[mt] : '0);
        check("Result", Result, er);
        check("LaneZero", LaneZero, ez);
    end

    function automatic logic [VW-1:0] vec(input int a0, input int a1,
                                          input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v[i*W +: W] = ($urandom % 2 == 0) ? W'($urandom % 3) : W'($urandom);
        end
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!Ready && n < 30) begin
            cyc();
            n++;
        end
        check("ready_wait", Ready, 1'b1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [VW-1:0] a,
                          input logic [VW-1:0] b, output int lat,
                          output int nctl, output logic err_at_done,
                          output logic [2:0] ctl_at_done);
        int n;
        wait_ready();
        Start = 1'b1;
        ALUControlIn = op;
        SrcA = a;
        SrcB = b;
        cyc();
        Start = 1'b0;
        SrcA = '1;
        SrcB = '1;
        ALUControlIn = 3'd0;
        n = 0;
        nctl = 0;
        while (!Done && n < 20) begin
            if (ALUControl == op) nctl++;
            cyc();
            n++;
        end
        lat = n + 1;
        err_at_done = Error;
        ctl_at_done = ALUControl;
    endtask

    initial begin
        int lat, nctl, dones, n;
        logic ed;
        logic [2:0] cd;

        rst_n = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        ALUControlIn = 3'd0;
        SrcA = '0;
        SrcB = '0;
        #1;
        check("rst_ready", Ready, 1'b1);
        check("rst_done", Done, 1'b0);
        check("rst_error", Error, 1'b0);
        check("rst_result", Result, '0);
        check("rst_lanezero", LaneZero, '0);
        check("rst_aluctl", ALUControl, 3'd0);
        #11;
        rst_n = 1'b1;

        // addv, accepted at the first edge after reset release
        run_op(3'd0, vec(1, 2, 3, 4), vec(10, 20, 30, 40), lat, nctl, ed, cd);
        check("addv_latency", lat, 5);
        check("addv_result", Result, vec(11, 22, 33, 44));
        check("addv_lanezero", LaneZero, 4'b0000);

        run_op(3'd1, vec(5, 0, 7, 9), vec(5, 0, 7, 9), lat, nctl, ed, cd);
        check("subv_ctl_cycles", nctl, 4);
        check("subv_latency", lat, 5);
        check("subv_result", Result, '0);
        check("subv_lanezero", LaneZero, 4'b1111);

        run_op(3'd7, vec(1, 1, 1, 1), vec(2, 2, 2, 2), lat, nctl, ed, cd);
        check("bad_latency", lat, 1);
        check("bad_error", ed, 1'b1);
        check("bad_aluctl", cd, 3'd0);
        check("bad_result", Result, '0);
        check("bad_lanezero", LaneZero, 4'b1111);

        // Abort after lane 1 has been written
        wait_ready();
        Start = 1'b1;
        ALUControlIn = 3'd0;
        SrcA = vec(1, 2, 3, 4);
        SrcB = vec(1, 1, 1, 1);
        cyc();
        Start = 1'b0;
        cyc();
        cyc();
        Abort = 1'b1;
        #0;
        check("abort_no_done", Done, 1'b0);
        cyc();
        Abort = 1'b0;
        check("abort_ready", Ready, 1'b1);
        check("abort_result", Result, vec(2, 3, 0, 0));
        check("abort_lanezero", LaneZero, 4'b1100);
        Start = 1'b1;
        Abort = 1'b1;
        cyc();
        check("start_abort_idle", Ready, 1'b1);
        Start = 1'b0;
        Abort = 1'b0;

        // Start held high: one operation every LANES+2 cycles
        wait_ready();
        Start = 1'b1;
        ALUControlIn = 3'd2;
        SrcA = vec(3, 0, 5, 7);
        SrcB = vec(4, 9, 6, 1);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (Done) dones++;
        end
        Start = 1'b0;
        check("held_dones", dones, 5);
        check("held_result", Result, vec(12, 0, 30, 7));
        check("held_lanezero", LaneZero, 4'b0010);

        // Reset pulse during lane 2 of an operation
        wait_ready();
        Start = 1'b1;
        ALUControlIn = 3'd0;
        SrcA = vec(1, 2, 3, 4);
        SrcB = vec(10, 20, 30, 40);
        cyc();
        Start = 1'b0;
        cyc();
        cyc();
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", Ready, 1'b1);
        check("mid_rst_done", Done, 1'b0);
        check("mid_rst_result", Result, '0);
        check("mid_rst_lanezero", LaneZero, '0);
        check("mid_rst_aluctl", ALUControl, 3'd0);
        check("mid_rst_srca", ALUSrcA, '0);
        #1 rst_n = 1'b1;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        check("post_rst_accept", Ready, 1'b0);
        n = 0;
        while (!Done && n < 20) begin
            cyc();
            n++;
        end
        check("post_rst_latency", n + 1, 5);
        check("post_rst_result", Result, vec(11, 22, 33, 44));

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            Start = ($urandom % 2 == 0);
            ALUControlIn = ($urandom % 4 == 0) ? 3'($urandom_range(3, 7))
                                               : 3'($urandom_range(0, 2));
            SrcA = rand_vec();
            SrcB = ($urandom % 4 == 0) ? SrcA : rand_vec();
            Abort = ($urandom % 25 == 0);
            if ($urandom % 300 == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            cyc();
        end
        Start = 1'b0;
        Abort = 1'b0;
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 Parameter: LANES, 4, number of vector lanes processed per operation.
REQ-002 Parameter: LANE_W, 32, width in bits of one lane and of the shared ALU datapath.
REQ-003 Port: clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: Start  input  1  request valid; accepted only when Ready=1.
REQ-006 Port: ALUControlIn  input  3  vector op code: 000 addv, 001 subv, 010 mulv.
REQ-007 Port: SrcA  input  LANES*LANE_W  vector operand A; lane i = bits [i*LANE_W +: LANE_W].
REQ-008 Port: SrcB  input  LANES*LANE_W  vector operand B, same lane mapping.
REQ-009 Port: Abort  input  1  flush of the current operation.
REQ-010 Port: Ready  output  1  high in IDLE only.
REQ-011 Port: ALUControl  output  3  op code driven to the shared ALU.
REQ-012 Port: ALUSrcA  output  LANE_W  lane operand A to the shared ALU.
REQ-013 Port: ALUSrcB  output  LANE_W  lane operand B to the shared ALU.
REQ-014 Port: ALUResult  input  LANE_W  combinational result from the shared ALU, same cycle.
REQ-015 Port: Result  output  LANES*LANE_W  assembled vector result.
REQ-016 Port: LaneZero  output  LANES  per-lane flag, high when that lane's result is zero.
REQ-017 Port: Done  output  1  one-cycle completion pulse.
REQ-018 Port: Error  output  1  one-cycle pulse, coincident with Done, for an unsupported op code.

Function
REQ-019 The block SHALL implement the states IDLE, ISSUE and FINISH.
REQ-020 In IDLE, Start=1 SHALL latch ALUControlIn, SrcA and SrcB, clear the lane counter, and move to ISSUE, or to FINISH if the op code is unsupported.
REQ-021 Op codes 011 through 111 SHALL be unsupported; they SHALL produce Error=1 with Done=1 and leave Result and LaneZero unchanged.
REQ-022 In ISSUE, the block SHALL drive lane k of the latched operands on ALUSrcA/ALUSrcB with the latched op code on ALUControl, where k is the lane counter.
REQ-023 At each ISSUE clock edge, the block SHALL write ALUResult into Result lane k, set LaneZero[k] to (ALUResult==0), and increment k.
REQ-024 When k=LANES-1 at an ISSUE edge, the block SHALL move to FINISH; the counter SHALL NOT wrap within an operation.
REQ-025 Lanes SHALL be processed in ascending order, starting at lane 0.
REQ-026 In FINISH, the block SHALL assert Done for exactly one cycle and return to IDLE on the next edge.
REQ-027 Latency SHALL be LANES+1 cycles from the accepting edge to Done, and 1 cycle for an unsupported op.
REQ-028 Back-to-back operations SHALL be possible: Start may be accepted in the cycle after Done.
REQ-029 Start while Ready=0 SHALL be ignored, with no effect on latched operands or state.
REQ-030 Outside ISSUE, ALUControl SHALL be 000 and ALUSrcA/ALUSrcB SHALL be 0.
REQ-031 Abort=1 in ISSUE or FINISH SHALL force IDLE at the next edge with no Done or Error pulse.
REQ-032 On Abort, Result lanes already written SHALL retain their values.
REQ-033 Abort in IDLE SHALL have no effect; when Abort and Start are both high in IDLE, Abort SHALL take priority and the request SHALL NOT be accepted.
REQ-034 Result and LaneZero SHALL hold their values between operations.

Reset
REQ-035 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, Ready=1, Done=0, Error=0, Result=0, LaneZero=0, lane counter=0, ALUControl=000 and ALUSrcA/ALUSrcB=0.
REQ-036 Reset asserted mid-operation SHALL discard the operation with no Done pulse.
REQ-037 After rst_n deasserts, Start SHALL be accepted at the first clock edge.

Verification
REQ-038 addv: SrcA lanes {1,2,3,4}, SrcB lanes {10,20,30,40}, ALU model behaving as an adder -> Done exactly 5 cycles after accept, Result lanes {11,22,33,44}, LaneZero=0000.
REQ-039 subv with A=B={5,0,7,9} -> ALUControl=001 during all 4 ISSUE cycles, Result=0, LaneZero=1111.
REQ-040 Op 111 -> Done=1 and Error=1 in the same single cycle, 1 cycle after accept, Result unchanged, ALUControl stays 000.
REQ-041 Abort after lane 1 is written -> IDLE next cycle, no Done, Result lanes 0-1 updated and lanes 2-3 unchanged; Start and Abort both high in IDLE -> request not accepted.
REQ-042 Start held high continuously -> new operation accepted the cycle after each Done; Start toggled while busy -> ignored.
REQ-043 rst_n pulsed low during ISSUE lane 2 -> outputs reach reset values without a clock edge, no Done, next Start accepted normally.
